// File: rtl/multi_state_sequencer.sv
// multi_state_sequencer: step-code sequencer for the multicycle MIPS controller.
// Define MULTI_SEQ_PERF_EN to add the cycle_cnt/stall_cnt performance counters.
module multi_state_sequencer #(
    parameter int         CNT_W    = 32,
    parameter logic [2:0] MAX_STEP = 3'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stall,
    input  logic [5:0]       Op,
    input  logic             next_ins,
    output logic [2:0]       state,
    output logic             ins_start,
    output logic             ins_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic             seq_err
`ifdef MULTI_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    localparam logic [CNT_W-1:0] ONE = 1;
    logic [2:0]       state_q, state_d, last;
    logic             done_q, done_d, ill_q, ill_d, err_q, err_d, adv, legal;
    logic [CNT_W-1:0] ret_q, ret_d;
    assign adv   = en & ~stall;
    assign legal = Op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    assign last  = (Op == 6'b100011) ? 3'd4 : (Op == 6'b000100 || Op == 6'b000010) ? 3'd2 : 3'd3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
        end
    end
    // Pulses are cleared on every edge, so a stall never stretches them.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        err_d   = err_q;
        ret_d   = ret_q;
        if (adv) begin
            if (state_q == 3'd0) begin
                state_d = 3'd1;
            end else if (state_q == 3'd1 && !legal) begin
                state_d = 3'd0;
                ill_d   = 1'b1;
            end else if (next_ins || state_q == MAX_STEP) begin
                state_d = 3'd0;
                done_d  = 1'b1;
                ret_d   = ret_q + ONE;
                err_d   = err_q | ~next_ins | (state_q != last);
            end else begin
                state_d = state_q + 3'd1;
                err_d   = err_q | (state_q == last);
            end
        end
    end
    always_comb begin
        state      = state_q;
        ins_start  = (state_q == 3'd0) & adv;
        ins_done   = done_q;
        illegal_op = ill_q;
        seq_err    = err_q;
        retired    = ret_q;
    end
`ifdef MULTI_SEQ_PERF_EN
    logic [CNT_W-1:0] cyc_q, stl_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_q + (en ? ONE : '0);
            stl_q <= stl_q + ((en & stall) ? ONE : '0);
        end
    end
    assign cycle_cnt = cyc_q;
    assign stall_cnt = stl_q;
`endif
endmodule
